display_scanner: RTL and testbench
==================================

# display_scanner

Time-multiplexed 7-segment driver that consumes the `DEC`-digit `BCDnumber_t` vector produced by the cascaded BCD counter. It scans one digit per slot on common-anode displays. Between slots it inserts a guard interval with all anodes off to suppress ghosting. It also blanks leading zeros and shows a dash for non-BCD values. It is the last stage before the board pins in the debouncer/counter design.

## Interface
- `DEC`, 4: number of digits scanned; ≥ 2.
- `REFRESH_DIV`, 50000: clock cycles per digit slot, guard included.
- `GUARD_CYC`, 500: cycles at the start of each slot with all anodes off; 1 ≤ `GUARD_CYC` < `REFRESH_DIV`.
- `LEAD_BLANK`, 1: 1 enables leading-zero blanking.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  display enable; 0 forces all anodes off while scanning continues.
- `digit`  in  `DEC` × `digito_pkg::BCDnumber_t`  digits, index 0 = least significant; fields `digito[3:0]`, `dp`.
- `an`  out  `DEC`  anode selects, active-low, one-hot-low when lit.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `slot`  out  `$clog2(DEC)`  index of the digit currently scanned.

## Operation
- Registers: prescaler `cnt` (0..`REFRESH_DIV`-1), digit index `idx` (0..`DEC`-1), FSM state {GUARD, SHOW}.
- `cnt` increments every cycle.
- **GUARD** covers `cnt` = 0..`GUARD_CYC`-1.
  - `an` = all 1, `seg` = 7'h7F, `dp` = 1.
- **GUARD→SHOW** occurs on the edge where `cnt` = `GUARD_CYC`-1. On that edge:
  - `seg`/`dp` are loaded from the decode of `digit[idx]`, sampled on that edge.
  - `an` is loaded with `~(1<<idx)`, or all 1 if `en` = 0.
- **SHOW** covers `cnt` = `GUARD_CYC`..`REFRESH_DIV`-1.
  - `seg`/`dp` hold the captured value; a `digit` change mid-slot is not reflected until the next slot.
  - `en` is re-evaluated every cycle: `en` = 0 forces `an` = all 1 on the next edge; `en` = 1 restores `~(1<<idx)` on the next edge.
- **SHOW→GUARD** occurs on the edge where `cnt` = `REFRESH_DIV`-1. On that edge:
  - `cnt` ← 0.
  - `idx` ← `idx`+1, wrapping `DEC`-1 → 0.
  - `an` ← all 1, `seg` ← 7'h7F, `dp` ← 1.
- `slot` = `idx`, registered.
- Decode (active-low, gfedcba):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex).
  - `digito` 10..15 → 3F (dash, segment g only).
- Leading-zero blank: applies when `LEAD_BLANK` = 1, `idx` ≠ 0, `digit[idx].digito` = 0, and every `digit[k].digito` with k > `idx` is 0.
  - Then `seg` ← 7F.
  - `dp` is still driven from `~digit[idx].dp`.
- `dp` ← `~digit[idx].dp` at capture.

## Timing
- Reset (asynchronous, `rst` = 0):
  - `cnt` = 0, `idx` = 0, `slot` = 0, state GUARD.
  - `an` = all 1, `seg` = 7'h7F, `dp` = 1.
- After reset release, `an[0]` first goes low on the `GUARD_CYC`-th rising edge.
- Each anode is low for exactly `REFRESH_DIV`-`GUARD_CYC` cycles per frame (with `en` = 1).
- Frame period = `DEC`·`REFRESH_DIV` cycles.
- No two anodes are ever low in the same cycle.
- Every anode transition (except an `en`-driven turn-off) is separated by at least `GUARD_CYC` all-off cycles.
- All outputs are registered; there is no combinational path from `digit`/`en` to any output.
- Reset asserted mid-slot turns all outputs off immediately, without waiting for a clock edge.

## Test plan
Parameters unless stated: `DEC` = 4, `REFRESH_DIV` = 8, `GUARD_CYC` = 2.
1. Reset and scan with `digit` = {4,3,2,1}, `en` = 1, release reset.
   - `an` = F for 2 cycles, then E for 6 cycles with `seg` = 79.
   - Then F for 2 cycles, then D with `seg` = 24, then B/30, then 7/19.
   - Wrap back to E on cycle 32.
2. Leading-zero blank with `digit` = {0,0,7,0}: slots 3 and 2 show `seg` = 7F; slot 1 shows 78; slot 0 shows 40.
   - With `LEAD_BLANK` = 0, slots 3 and 2 show 40.
3. Dash and decimal point: `digit[1]` = {digito 12, dp 1} gives `seg` = 3F and `dp` = 0 during slot 1 only.
4. Mid-slot change: change `digit[0]` from 5 to 6 at cycle 4 of slot 0.
   - `seg` stays 12 until the slot ends.
   - The next frame's slot 0 shows 02.
5. Enable gating: drop `en` for 3 cycles inside SHOW.
   - `an` = F during those cycles, offset by the one-cycle register delay.
   - `slot`/`cnt` progression is unaffected, and the anode returns on the next edge after `en` = 1.
6. Asynchronous reset mid-SHOW: assert `rst` = 0 between clock edges.
   - `an` = F, `seg` = 7F, `dp` = 1 immediately.
   - After release, the scan restarts from slot 0 with a full guard interval.

Source files
------------

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with per-slot guard interval,
// leading-zero blanking and dash display for non-BCD digit values.

package digito_pkg;
    typedef struct packed {
        logic [3:0] digito;
        logic       dp;
    } BCDnumber_t;
endpackage

module display_scanner #(
    parameter int unsigned DEC         = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD_CYC   = 500,
    parameter int unsigned LEAD_BLANK  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  digito_pkg::BCDnumber_t [DEC-1:0]    digit,
    output logic [DEC-1:0]                      an,
    output logic [6:0]                          seg,
    output logic                                dp,
    output logic [$clog2(DEC)-1:0]              slot
);

    localparam int unsigned IDX_W = $clog2(DEC);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEC - 1);
    localparam logic [DEC-1:0]   AN_OFF    = '1;
    localparam logic [6:0]       SEG_OFF   = 7'h7F;

    typedef enum logic {
        GUARD,
        SHOW
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [DEC-1:0]     an_nxt;
    logic [6:0]         seg_nxt;
    logic               dp_nxt;

    digito_pkg::BCDnumber_t cur;
    logic                   higher_zero;
    logic                   blank;
    logic [6:0]             show_seg;
    logic [DEC-1:0]         an_lit;

    // Active-low gfedcba; anything outside 0..9 becomes a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Digit decode for the current slot, including leading-zero suppression.
    always_comb begin
        cur         = digit[idx];
        higher_zero = 1'b1;
        for (int unsigned k = 0; k < DEC; k++) begin
            if ((k > 32'(idx)) && (digit[IDX_W'(k)].digito != 4'd0)) begin
                higher_zero = 1'b0;
            end
        end
        blank    = (LEAD_BLANK != 0) && (idx != '0) && (cur.digito == 4'd0) && higher_zero;
        show_seg = blank ? SEG_OFF : decode(cur.digito);
        an_lit   = en ? ~(DEC'(1) << idx) : AN_OFF;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == SLOT_END) ? '0 : cnt + CNT_W'(1);
        idx_nxt   = idx;
        an_nxt    = AN_OFF;
        seg_nxt   = SEG_OFF;
        dp_nxt    = 1'b1;

        case (state)
            GUARD: begin
                if (cnt == GUARD_END) begin
                    state_nxt = SHOW;
                    an_nxt    = an_lit;
                    seg_nxt   = show_seg;
                    dp_nxt    = ~cur.dp;
                end
            end
            SHOW: begin
                if (cnt == SLOT_END) begin
                    state_nxt = GUARD;
                    idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end else begin
                    an_nxt  = an_lit;
                    seg_nxt = seg;
                    dp_nxt  = dp;
                end
            end
            default: state_nxt = GUARD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= GUARD;
            cnt   <= '0;
            idx   <= '0;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
            dp    <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            an    <= an_nxt;
            seg   <= seg_nxt;
            dp    <= dp_nxt;
        end
    end

    assign slot = idx;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: per-cycle expected outputs are queued by
// the stimulus and popped/compared by a monitor on every falling clock edge.

module tb_display_scanner;

    localparam int unsigned GC = 2;
    localparam int unsigned RD = 8;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [6:0] seg_nb;
        logic       dp;
        logic [1:0] slot;
        int         ph;
        int         cyc;
    } exp_t;

    logic                             clk;
    logic                             rst;
    logic                             en;
    digito_pkg::BCDnumber_t [3:0]     digit;
    logic [3:0]                       an,     an_nb;
    logic [6:0]                       seg,    seg_nb;
    logic                             dp,     dp_nb;
    logic [1:0]                       slot,   slot_nb;

    exp_t sb_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   ph    = 0;
    int   pcyc  = 0;

    display_scanner #(.DEC(4), .REFRESH_DIV(RD), .GUARD_CYC(GC), .LEAD_BLANK(1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .digit(digit),
        .an(an), .seg(seg), .dp(dp), .slot(slot)
    );

    display_scanner #(.DEC(4), .REFRESH_DIV(RD), .GUARD_CYC(GC), .LEAD_BLANK(0)) u_dut_nb (
        .clk(clk), .rst(rst), .en(en), .digit(digit),
        .an(an_nb), .seg(seg_nb), .dp(dp_nb), .slot(slot_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want,
                       input int p, input int c);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s ph%0d cyc%0d got=%h want=%h", nm, p, c, act, want);
        end
    endtask

    // Monitor: one expected entry per clock cycle, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("an",      8'(an),      8'(e.an),     e.ph, e.cyc);
                chk("seg",     8'(seg),     8'(e.seg),    e.ph, e.cyc);
                chk("dp",      8'(dp),      8'(e.dp),     e.ph, e.cyc);
                chk("slot",    8'(slot),    8'(e.slot),   e.ph, e.cyc);
                chk("an_nb",   8'(an_nb),   8'(e.an),     e.ph, e.cyc);
                chk("seg_nb",  8'(seg_nb),  8'(e.seg_nb), e.ph, e.cyc);
                chk("dp_nb",   8'(dp_nb),   8'(e.dp),     e.ph, e.cyc);
                chk("slot_nb", 8'(slot_nb), 8'(e.slot),   e.ph, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog ph%0d got=timeout want=finish", ph);
        $fatal(1, "watchdog");
    end

    task automatic start_phase(input int p);
        ph   = p;
        pcyc = 0;
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        digit[3] = '{digito: d3, dp: 1'b0};
        digit[2] = '{digito: d2, dp: 1'b0};
        digit[1] = '{digito: d1, dp: 1'b0};
        digit[0] = '{digito: d0, dp: 1'b0};
    endtask

    // Pushes the first n cycles of one slot: guard cycles dark, then the shown digit.
    task automatic push_slot_n(input logic [3:0] an_on, input logic [6:0] sg,
                               input logic [6:0] sg_nb, input logic dp_on,
                               input logic [1:0] sl, input logic [7:0] off_mask, input int n);
        exp_t x;
        for (int j = 0; j < n; j++) begin
            x.an     = (j < int'(GC) || off_mask[j]) ? 4'hF : an_on;
            x.seg    = (j < int'(GC)) ? 7'h7F : sg;
            x.seg_nb = (j < int'(GC)) ? 7'h7F : sg_nb;
            x.dp     = (j < int'(GC)) ? 1'b1  : dp_on;
            x.slot   = sl;
            x.ph     = ph;
            x.cyc    = pcyc;
            pcyc++;
            sb_q.push_back(x);
        end
    endtask

    task automatic push_slot(input logic [3:0] an_on, input logic [6:0] sg,
                             input logic [6:0] sg_nb, input logic dp_on, input logic [1:0] sl);
        push_slot_n(an_on, sg, sg_nb, dp_on, sl, 8'h00, int'(RD));
    endtask

    task automatic push_off(input int n);
        push_slot_n(4'hF, 7'h7F, 7'h7F, 1'b1, 2'd0, 8'hFF, n);
    endtask

    task automatic push_4321();
        push_slot(4'hE, 7'h79, 7'h79, 1'b1, 2'd0);
        push_slot(4'hD, 7'h24, 7'h24, 1'b1, 2'd1);
        push_slot(4'hB, 7'h30, 7'h30, 1'b1, 2'd2);
        push_slot(4'h7, 7'h19, 7'h19, 1'b1, 2'd3);
    endtask

    task automatic hold_rst();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain ph%0d got=%0d want=0 entries left", ph, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        repeat (3) @(posedge clk);

        // Plain scan of 4321 plus wrap into the next frame.
        set_digits(4'd4, 4'd3, 4'd2, 4'd1);
        start_phase(1);
        release_rst();
        push_4321();
        push_slot(4'hE, 7'h79, 7'h79, 1'b1, 2'd0);
        drain(80);

        // Leading-zero blanking vs. no blanking.
        hold_rst();
        set_digits(4'd0, 4'd0, 4'd7, 4'd0);
        start_phase(2);
        release_rst();
        push_slot(4'hE, 7'h40, 7'h40, 1'b1, 2'd0);
        push_slot(4'hD, 7'h78, 7'h78, 1'b1, 2'd1);
        push_slot(4'hB, 7'h7F, 7'h40, 1'b1, 2'd2);
        push_slot(4'h7, 7'h7F, 7'h40, 1'b1, 2'd3);
        drain(80);

        // Dash and decimal point on slot 1.
        hold_rst();
        set_digits(4'd0, 4'd3, 4'd12, 4'd8);
        digit[1].dp = 1'b1;
        start_phase(3);
        release_rst();
        push_slot(4'hE, 7'h00, 7'h00, 1'b1, 2'd0);
        push_slot(4'hD, 7'h3F, 7'h3F, 1'b0, 2'd1);
        push_slot(4'hB, 7'h30, 7'h30, 1'b1, 2'd2);
        push_slot(4'h7, 7'h7F, 7'h40, 1'b1, 2'd3);
        drain(80);

        // Mid-slot digit change only shows up in the next frame.
        hold_rst();
        set_digits(4'd0, 4'd0, 4'd1, 4'd5);
        start_phase(4);
        release_rst();
        push_slot(4'hE, 7'h12, 7'h12, 1'b1, 2'd0);
        push_slot(4'hD, 7'h79, 7'h79, 1'b1, 2'd1);
        push_slot(4'hB, 7'h7F, 7'h40, 1'b1, 2'd2);
        push_slot(4'h7, 7'h7F, 7'h40, 1'b1, 2'd3);
        push_slot(4'hE, 7'h02, 7'h02, 1'b1, 2'd0);
        repeat (5) @(negedge clk);
        digit[0].digito = 4'd6;
        drain(80);

        // en low for cycles 11..13; anode dark on cycles 12..14 of the run.
        hold_rst();
        set_digits(4'd4, 4'd3, 4'd2, 4'd1);
        start_phase(5);
        release_rst();
        push_slot(4'hE, 7'h79, 7'h79, 1'b1, 2'd0);
        push_slot_n(4'hD, 7'h24, 7'h24, 1'b1, 2'd1, 8'h70, int'(RD));
        push_slot(4'hB, 7'h30, 7'h30, 1'b1, 2'd2);
        push_slot(4'h7, 7'h19, 7'h19, 1'b1, 2'd3);
        repeat (12) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        drain(80);

        // Asynchronous reset in the middle of slot 1's SHOW phase.
        hold_rst();
        start_phase(6);
        release_rst();
        push_slot(4'hE, 7'h79, 7'h79, 1'b1, 2'd0);
        push_slot_n(4'hD, 7'h24, 7'h24, 1'b1, 2'd1, 8'h00, 4);
        repeat (12) @(negedge clk);
        hold_rst();
        push_off(1);
        start_phase(7);
        release_rst();
        push_4321();
        drain(80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
